ladybird_iram_arbiter: RTL
==========================

# ladybird_iram_arbiter

Two-port arbiter that shares a single instruction-RAM bus slave between the core's instruction-fetch port (port 0) and a loader/debug port (port 1), e.g. for boot-time program download. It sits between the two requesters and the instruction RAM. It muxes requests onto the shared bus, tracks outstanding reads in order, and steers each read response back to the port that issued it.

## Interface
Parameters:
- MAX_OUTSTANDING, 4: read responses that may be in flight at once (power of two, ≥2).
- FIXED_PRIORITY, 0: 0 = round-robin, 1 = port 0 always wins.

Ports:
- clk  input  1  clock
- nrst  input  1  reset; synchronous, active-low
- req0  ladybird_bus_interface.secondary  —  port 0 (instruction fetch) upstream bus
- req1  ladybird_bus_interface.secondary  —  port 1 (loader/debug) upstream bus
- mem  ladybird_bus_interface.primary  —  shared downstream bus to the instruction RAM
- err  output  1  sticky protocol error: a response arrived with no read outstanding

## Operation
- Request classes: a write has req=1 and |wstrb≠0, and produces no response. A read has req=1 and wstrb=0, and expects exactly one rdgnt pulse later.
- Selection uses the requests of the current cycle:
  - One port requesting: that port is selected.
  - Both requesting, FIXED_PRIORITY=1: port 0.
  - Both requesting, round-robin: the port not granted last.
- last_grant register: updated only on an accepted transfer, i.e. when the selected port's gnt=1.
- Downstream drive (combinational): mem.req = selected req, and additionally 0 for a read while the FIFO is full. mem.addr, mem.wdata and mem.wstrb come from the selected port.
- Upstream gnt: the selected port gets gnt = mem.gnt & ~(read & full). The unselected port gets gnt=0.
- Outstanding FIFO (depth MAX_OUTSTANDING, 1-bit port id): push the selected id on an accepted read. Writes never push.
- Response: when mem.rdgnt=1, the FIFO head id chooses which port gets rdgnt=1 and the head is popped. The other port gets rdgnt=0.
- rdata: mem.rdata is broadcast to both ports; it is valid only with that port's rdgnt.
- Push and pop in the same cycle are allowed at any count (count unchanged). The full check uses the registered count, not count-after-pop.
- mem.rdgnt while the FIFO is empty: the response is dropped, no upstream rdgnt, and err is set until reset.

## Timing
- Request path has zero added latency: upstream req → mem.req/gnt within the same cycle.
- Response path has zero added latency: mem.rdgnt/rdata → upstream rdgnt/rdata within the same cycle.
- Downstream RAM with 1-cycle read returns rdgnt at t+1 for a read accepted at t. Back-to-back reads sustain 1 per cycle.
- Responses are strictly in order; the downstream slave is required to be in-order.
- Reset values (while nrst=0 and the first cycle after):
  - FIFO count=0, last_grant=port 1 (so port 0 wins the first tie), err=0.
  - req0.gnt, req1.gnt, req0.rdgnt, req1.rdgnt and mem.req are all forced 0 while nrst=0.
- Reset mid-operation: in-flight reads are discarded. A late mem.rdgnt after reset release sets err.

## Structure
- Shared constants and types belong in ladybird_config: XLEN, and typedef port_id_t (1 bit) with PORT_FETCH=0 and PORT_LOADER=1.
- One sub-module, ladybird_id_fifo: synchronous FIFO parameterised by DEPTH and WIDTH. It has push, pop, din, dout, full, empty and count, resets on nrst, and allows simultaneous push/pop.
- The arbiter top holds the selection logic, last_grant, the muxing and err.

## Test plan
- Reset: hold nrst=0 for 3 cycles with both req=1 → all gnt, rdgnt and mem.req are 0, err=0. On the first cycle after release, port 0 is granted.
- Round-robin: both ports issue continuous reads to 0x0/0x40 → grants alternate 0,1,0,1. Each rdgnt arrives one cycle later, on the issuing port only, with the matching data.
- Fixed priority (FIXED_PRIORITY=1): both request for 5 cycles → port 1 gnt stays 0 until port 0 drops req.
- Outstanding full: stub slave holds responses, 5 reads issued with MAX_OUTSTANDING=4 → the 5th gets gnt=0 and mem.req=0. It is granted in the cycle after the first rdgnt pops an entry.
- Mixed traffic: port 1 writes 0x00000013 to address 0x8 (wstrb=4'hF) while port 0 reads address 0x8 in the next cycle → no rdgnt for the write, port 0 reads back 0x00000013, FIFO count returns to 0.
- Spurious response: pulse mem.rdgnt with the FIFO empty → no upstream rdgnt, err=1 and stays 1 until nrst.

Source files
------------

// File: rtl/ladybird_config.sv
// rtl/ladybird_config.sv - shared bus width and requester id type for the iram arbiter
package ladybird_config;

    localparam int XLEN = 32;

    typedef enum logic {
        PORT_FETCH  = 1'b0,
        PORT_LOADER = 1'b1
    } port_id_t;

endpackage

// File: rtl/ladybird_bus_interface.sv
// rtl/ladybird_bus_interface.sv - req/gnt bus with split read response (rdgnt/rdata)
interface ladybird_bus_interface;
    import ladybird_config::*;

    logic              req;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [XLEN/8-1:0] wstrb;
    logic              gnt;
    logic              rdgnt;
    logic [XLEN-1:0]   rdata;

    modport primary   (output req, addr, wdata, wstrb, input  gnt, rdgnt, rdata);
    modport secondary (input  req, addr, wdata, wstrb, output gnt, rdgnt, rdata);

endinterface

// File: rtl/ladybird_id_fifo.sv
// rtl/ladybird_id_fifo.sv - small synchronous FIFO, simultaneous push/pop allowed at any fill level
module ladybird_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = store[rd_ptr];
    // a push into a full FIFO is fine when the head leaves in the same cycle
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                store[wr_ptr] <= din;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/ladybird_iram_arbiter.sv
// rtl/ladybird_iram_arbiter.sv - shares the instruction RAM between fetch (port 0) and loader (port 1)
module ladybird_iram_arbiter
    import ladybird_config::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int FIXED_PRIORITY  = 0
) (
    input  logic                   clk,
    input  logic                   nrst,
    ladybird_bus_interface.secondary req0,
    ladybird_bus_interface.secondary req1,
    ladybird_bus_interface.primary   mem,
    output logic                   err
);

    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    port_id_t         last_grant;
    port_id_t         sel;
    logic             any_req;
    logic             sel_loader;
    logic [XLEN/8-1:0] sel_wstrb;
    logic             sel_read;
    logic             blocked;
    logic             accept;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [0:0]       sel_bits;
    logic [0:0]       head_bits;

    always_comb begin
        sel = PORT_FETCH;
        if (req0.req && req1.req) begin
            if (FIXED_PRIORITY != 0) begin
                sel = PORT_FETCH;
            end else begin
                sel = (last_grant == PORT_FETCH) ? PORT_LOADER : PORT_FETCH;
            end
        end else if (req1.req) begin
            sel = PORT_LOADER;
        end
    end

    assign any_req    = req0.req | req1.req;
    assign sel_loader = (sel == PORT_LOADER);
    assign sel_wstrb  = sel_loader ? req1.wstrb : req0.wstrb;
    assign sel_read   = ~|sel_wstrb;
    // full is judged on the registered count so a same-cycle response cannot unblock a read
    assign blocked    = sel_read & fifo_full;

    assign mem.req    = nrst & any_req & ~blocked;
    assign mem.addr   = sel_loader ? req1.addr  : req0.addr;
    assign mem.wdata  = sel_loader ? req1.wdata : req0.wdata;
    assign mem.wstrb  = sel_wstrb;

    assign accept     = mem.req & mem.gnt;
    assign req0.gnt   = accept & ~sel_loader;
    assign req1.gnt   = accept &  sel_loader;

    assign fifo_push  = accept & sel_read;
    assign fifo_pop   = nrst & mem.rdgnt & ~fifo_empty;
    assign sel_bits   = sel;

    assign req0.rdgnt = fifo_pop & (head_bits == PORT_FETCH);
    assign req1.rdgnt = fifo_pop & (head_bits == PORT_LOADER);
    assign req0.rdata = mem.rdata;
    assign req1.rdata = mem.rdata;

    ladybird_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (1)
    ) u_id_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (sel_bits),
        .dout  (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            last_grant <= PORT_LOADER;
            err        <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= sel;
            end
            if (mem.rdgnt && fifo_count == '0) begin
                err <= 1'b1;
            end
        end
    end

endmodule
